rcs_div_ctrl: RTL



---
 rtl/rcs_pkg.sv | 21 ++
 rtl/rcs_8bit.sv | 35 +++
 rtl/rcs_div_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rcs_pkg.sv
// ---------------------------------------------------------------------------
// rcs_pkg: shared types and constants for the rcs_div_ctrl divider.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rcs_pkg;

  localparam int                   RCS_WIDTH         = 8;
  localparam logic [2:0]           RCS_ITER_LAST     = 3'd7;
  localparam logic [RCS_WIDTH-1:0] RCS_DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rcs_state_e;

endpackage

`default_nettype wire

// File: rtl/rcs_8bit.sv
// ---------------------------------------------------------------------------
// rcs_8bit: 8-bit ripple-carry subtractor, diff = a - b, carry_o=1 when a>=b.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcs_8bit
  import rcs_pkg::*;
(
  input  logic [RCS_WIDTH-1:0] a_i,
  input  logic [RCS_WIDTH-1:0] b_i,
  output logic [RCS_WIDTH-1:0] diff_o,
  output logic                 carry_o
);

  logic [RCS_WIDTH:0] c_w;
  logic [RCS_WIDTH-1:0] nb_w;

  // Subtraction as a + ~b + 1; the final carry is the inverted borrow.
  assign c_w[0] = 1'b1;
  assign nb_w   = ~b_i;

  genvar gi;
  generate
    for (gi = 0; gi < RCS_WIDTH; gi++) begin : g_bit
      assign diff_o[gi] = a_i[gi] ^ nb_w[gi] ^ c_w[gi];
      assign c_w[gi+1]  = (a_i[gi] & nb_w[gi]) | (c_w[gi] & (a_i[gi] ^ nb_w[gi]));
    end
  endgenerate

  assign carry_o = c_w[RCS_WIDTH];

endmodule

`default_nettype wire

// File: rtl/rcs_div_ctrl.sv
// ---------------------------------------------------------------------------
// rcs_div_ctrl: 8-bit restoring divider iterating over one shared rcs_8bit.
// Optional early divide-by-zero exit: RCS_DIV_ZERO_DETECT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcs_div_ctrl
  import rcs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RCS_WIDTH-1:0] dividend,
  input  logic [RCS_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [RCS_WIDTH-1:0] quotient,
  output logic [RCS_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  rcs_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [RCS_WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [RCS_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;

  logic [RCS_WIDTH:0]   s_w;
  logic [RCS_WIDTH-1:0] diff_w, r_next_w, q_next_w;
  logic                 carry_w, take_w;

  assign s_w = {r_q, q_q[RCS_WIDTH-1]};

  rcs_8bit u_sub (
    .a_i     (s_w[RCS_WIDTH-1:0]),
    .b_i     (d_q),
    .diff_o  (diff_w),
    .carry_o (carry_w)
  );

  // A set S[8] means S exceeds 255 and is therefore >= D regardless of borrow.
  assign take_w   = s_w[RCS_WIDTH] | carry_w;
  assign r_next_w = take_w ? diff_w : s_w[RCS_WIDTH-1:0];
  assign q_next_w = {q_q[RCS_WIDTH-2:0], take_w};

`ifdef RCS_DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef RCS_DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = 3'd0;
          state_d = RUN;
`ifdef RCS_DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = RCS_DIV0_QUOTIENT;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        r_d   = r_next_w;
        q_d   = q_next_w;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == RCS_ITER_LAST) begin
          state_d = DONE;
          quo_d   = q_next_w;
          rem_d   = r_next_w;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef RCS_DIV_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= dz_d;
  end
  assign div_by_zero = (state_q == DONE) & dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire
